// File: rtl/sort_if.sv
// Host-side bus of the sorting memory: load/read port plus start/done handshake.
// The host drives the master modport; sort_top owns the slave modport.
interface sort_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  s;
    logic                  done;
    logic [ADDR_WIDTH-1:0] Radd;
    logic [DATA_WIDTH-1:0] datain;
    logic                  wrin;
    logic                  rd;
    logic [DATA_WIDTH-1:0] DOUT;

    modport master (
        output s, Radd, datain, wrin, rd,
        input  done, DOUT
    );

    modport slave (
        input  s, Radd, datain, wrin, rd,
        output done, DOUT
    );
endinterface

// File: rtl/sort_top.sv
// Register-array memory with an in-place ascending bubble sorter, one compare-and-swap per clock.
// Words are unsigned; done is held until the host releases start.
module sort_top #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic  clk,
    input  logic  rstn,
    sort_if.slave bus
);
    localparam int N = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 2);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] mem_r [N];
    logic [ADDR_WIDTH-1:0] i_r;
    logic [ADDR_WIDTH-1:0] j_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] dout_r;

    logic [DATA_WIDTH-1:0] lo_s;
    logic [DATA_WIDTH-1:0] hi_s;
    logic                  swap_s;
    logic                  pass_end_s;

    assign bus.done = done_r;
    assign bus.DOUT = dout_r;

    // Operand pair for the current compare; the last j of a pass shrinks as i grows.
    always_comb begin
        lo_s       = mem_r[j_r];
        hi_s       = mem_r[j_r + ONE];
        swap_s     = (lo_s > hi_s);
        pass_end_s = (j_r == (LAST_IDX - i_r));
    end

    // Sequencer and memory array: host writes in IDLE, compare-and-swap in SORT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) begin
                mem_r[k] <= {DATA_WIDTH{1'b0}};
            end
            state_r <= IDLE;
            i_r     <= {ADDR_WIDTH{1'b0}};
            j_r     <= {ADDR_WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.wrin) begin
                        mem_r[bus.Radd] <= bus.datain;
                    end
                    if (bus.s) begin
                        state_r <= SORT;
                        i_r     <= {ADDR_WIDTH{1'b0}};
                        j_r     <= {ADDR_WIDTH{1'b0}};
                    end
                end
                SORT: begin
                    if (swap_s) begin
                        mem_r[j_r]       <= hi_s;
                        mem_r[j_r + ONE] <= lo_s;
                    end
                    if (pass_end_s) begin
                        j_r <= {ADDR_WIDTH{1'b0}};
                        if (i_r == LAST_IDX) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            i_r <= i_r + ONE;
                        end
                    end else begin
                        j_r <= j_r + ONE;
                    end
                end
                DONE: begin
                    if (!bus.s) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port, live in every state; sees the pre-edge word on a same-address write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_r <= {DATA_WIDTH{1'b0}};
        end else if (bus.rd) begin
            dout_r <= mem_r[bus.Radd];
        end else begin
            dout_r <= dout_r;
        end
    end
endmodule

// File: tb/tb_sort_top.sv
// Scoreboard bench for sort_top: reads push expected words, a monitor pops and compares DOUT.
module tb_sort_top;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sort_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sort_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every edge that samples rd=1 out of reset produces one DOUT word to check.
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            if (bus.rd && rstn) begin
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL read_unexpected actual=%0h expected=none", bus.DOUT);
                end else begin
                    e = sb.pop_front();
                    chk("read", {24'h0, bus.DOUT}, {24'h0, e});
                end
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.Radd   = a;
        bus.datain = d;
        bus.wrin   = 1'b1;
        @(negedge clk);
        bus.wrin   = 1'b0;
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] e);
        bus.Radd = a;
        bus.rd   = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.rd   = 1'b0;
    endtask

    // Vectors are packed with address 0 in the top byte.
    task automatic wr8(input logic [63:0] v);
        for (int k = 0; k < 8; k++) wr(AW'(k), v[63 - 8*k -: 8]);
    endtask

    task automatic rd8(input logic [63:0] v);
        for (int k = 0; k < 8; k++) rd1(AW'(k), v[63 - 8*k -: 8]);
    endtask

    // Start with s held; done must appear after E0 plus 28 compare edges (29 negedges).
    task automatic run_sort(input string name, input bit hold);
        int cnt;
        cnt   = 0;
        bus.s = 1'b1;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.done && cnt < 100);
        chk({name, "_latency"}, cnt, 29);
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk({name, "_done_hold"}, {31'h0, bus.done}, 32'h1);
            end
        end
        bus.s = 1'b0;
        @(negedge clk);
        chk({name, "_done_fall"}, {31'h0, bus.done}, 32'h0);
    endtask

    initial begin : stim
        int cnt;
        bus.s = 1'b0; bus.Radd = '0; bus.datain = '0; bus.wrin = 1'b0; bus.rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_dout", {24'h0, bus.DOUT}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: partial load, unwritten zeros take part in the sort
        for (int k = 0; k < 4; k++) wr(AW'(k), 8'hA0 + 8'(k));
        run_sort("t1", 1'b1);
        rd8(64'h00000000_A0A1A2A3);

        // 2: fully reversed
        wr8(64'h07060504_03020100);
        run_sort("t2", 1'b0);
        rd8(64'h00010203_04050607);

        // 3: unsigned compare with duplicates
        wr8(64'hFF008080_01FF7F00);
        run_sort("t3", 1'b1);
        rd8(64'h0000017F_8080FFFF);

        // 4: new write after done, s dropped mid-sort, wrin ignored while sorting
        wr(3'd3, 8'h05);
        bus.s = 1'b1;
        @(negedge clk);
        bus.s = 1'b0; bus.wrin = 1'b1; bus.Radd = 3'd0; bus.datain = 8'h42;
        cnt = 1;
        while (!bus.done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        bus.wrin = 1'b0;
        chk("t4_latency", cnt, 29);
        @(negedge clk);
        chk("t4_done_fall", {31'h0, bus.done}, 32'h0);
        rd8(64'h00000105_8080FFFF);

        // 5: reset at compare edge 10 aborts and clears everything
        wr8(64'h07060504_03020100);
        bus.s = 1'b1;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_done", {31'h0, bus.done}, 32'h0);
        chk("t5_dout", {24'h0, bus.DOUT}, 32'h0);
        rstn = 1'b1; bus.s = 1'b0;
        @(negedge clk);
        rd8(64'h0);
        wr(3'd0, 8'h03); wr(3'd1, 8'h01); wr(3'd2, 8'h02);
        run_sort("t5", 1'b0);
        rd8(64'h00000000_00010203);

        // 6: DOUT holds with rd=0; read and write to one address returns the old word
        rd1(3'd7, 8'h03);
        bus.Radd = 3'd0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_hold", {24'h0, bus.DOUT}, 32'h03);
        end
        rd1(3'd5, 8'h01);
        bus.Radd = 3'd6; bus.datain = 8'h99; bus.wrin = 1'b1; bus.rd = 1'b1;
        sb.push_back(8'h02);
        @(negedge clk);
        bus.wrin = 1'b0; bus.rd = 1'b0;
        rd1(3'd6, 8'h99);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
